// File: rtl/qr_pkg.sv
// Shared types and constants for the Givens-rotation QR scheduler.
package qr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  localparam int DW_DEF = 16;

endpackage

// File: rtl/qr_index_gen.sv
// Loop counters for the Givens schedule.
// Column-major pivots j, row pairs from the bottom up, vector at k=j then rotate k=j+1..COLS-1.
module qr_index_gen
  import qr_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          advance,
  output logic [RW-1:0] row_a,
  output logic [RW-1:0] row_b,
  output logic [CW-1:0] col,
  output logic          is_vec,
  output logic          first_op,
  output logic          last_op
);

  // number of pivot columns that need zeroing below the diagonal
  localparam int JN = ((ROWS - 1) < COLS) ? (ROWS - 1) : COLS;

  logic [CW-1:0] j;

  assign is_vec   = (col == j);
  assign first_op = (j == '0) && (row_b == RW'(ROWS - 1)) && (col == '0);
  assign last_op  = (int'(j) == JN - 1) && (int'(row_a) == int'(j)) &&
                    (int'(col) == COLS - 1);

  // step through the schedule; hold at the final op instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j     <= '0;
      row_a <= '0;
      row_b <= '0;
      col   <= '0;
    end else if (init) begin
      j     <= '0;
      row_a <= RW'(ROWS - 2);
      row_b <= RW'(ROWS - 1);
      col   <= '0;
    end else if (advance && !last_op) begin
      if (int'(col) < COLS - 1) begin
        col <= col + CW'(1);
      end else if (int'(row_a) > int'(j)) begin
        row_a <= row_a - RW'(1);
        row_b <= row_b - RW'(1);
        col   <= j;
      end else begin
        j     <= j + CW'(1);
        row_a <= RW'(ROWS - 2);
        row_b <= RW'(ROWS - 1);
        col   <= j + CW'(1);
      end
    end
  end

endmodule

// File: rtl/qr_givens_scheduler.sv
// Givens QR sequencer: drives one shared CORDIC through vector/rotate ops
// and writes results back into the external two-row register file.
module qr_givens_scheduler
  import qr_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = DW_DEF,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [RW-1:0]        rd_row_a,
  output logic [RW-1:0]        rd_row_b,
  output logic [CW-1:0]        rd_col,
  input  logic signed [DW-1:0] rd_a_data,
  input  logic signed [DW-1:0] rd_b_data,
  output logic                 wr_en,
  output logic signed [DW-1:0] wr_a_data,
  output logic signed [DW-1:0] wr_b_data,
  output logic                 cor_req_valid,
  input  logic                 cor_req_ready,
  output logic                 cor_mode,
  output logic signed [DW-1:0] cor_x,
  output logic signed [DW-1:0] cor_y,
  output logic signed [DW-1:0] cor_z,
  input  logic                 cor_rsp_valid,
  input  logic signed [DW-1:0] cor_x_out,
  input  logic signed [DW-1:0] cor_y_out,
  input  logic signed [DW-1:0] cor_z_out
);

  state_t              state;
  logic                first_q;
  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] y_q;
  logic signed [DW-1:0] angle_q;
  logic                is_vec;
  logic                first_op;
  logic                last_op;
  logic                idx_init;
  logic                idx_adv;

  assign idx_init = (state == IDLE) && start && !abort;
  assign idx_adv  = (state == WRITE) && !abort;

  qr_index_gen #(
    .ROWS(ROWS),
    .COLS(COLS),
    .RW  (RW),
    .CW  (CW)
  ) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (idx_init),
    .advance (idx_adv),
    .row_a   (rd_row_a),
    .row_b   (rd_row_b),
    .col     (rd_col),
    .is_vec  (is_vec),
    .first_op(first_op),
    .last_op (last_op)
  );

  // Indices move on the same edge as entering ISSUE, so the first ISSUE cycle
  // forwards the live read data and the held copy covers any backpressure.
  assign cor_x    = first_q ? rd_a_data : x_q;
  assign cor_y    = first_q ? rd_b_data : y_q;
  assign cor_mode = is_vec ? MODE_VEC : MODE_ROT;
  assign cor_z    = (cor_mode == MODE_ROT) ? angle_q : '0;

  // control FSM with registered strobes, operand hold and angle capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_en         <= 1'b0;
      cor_req_valid <= 1'b0;
      first_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      angle_q       <= '0;
      wr_a_data     <= '0;
      wr_b_data     <= '0;
    end else begin
      first_q <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        busy          <= 1'b0;
        cor_req_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state         <= ISSUE;
              busy          <= 1'b1;
              cor_req_valid <= 1'b1;
              first_q       <= 1'b1;
            end
          end
          ISSUE: begin
            if (first_q) begin
              x_q <= rd_a_data;
              y_q <= rd_b_data;
              // a fresh decomposition never inherits an angle from a previous run
              if (first_op) angle_q <= '0;
            end
            if (cor_req_ready) begin
              cor_req_valid <= 1'b0;
              state         <= WAIT;
            end
          end
          WAIT: begin
            if (cor_rsp_valid) begin
              state     <= WRITE;
              wr_en     <= 1'b1;
              wr_a_data <= cor_x_out;
              // the zeroed element is forced exactly, CORDIC residue is dropped
              wr_b_data <= is_vec ? '0 : cor_y_out;
              if (is_vec) angle_q <= cor_z_out;
            end
          end
          WRITE: begin
            if (last_op) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state         <= ISSUE;
              cor_req_valid <= 1'b1;
              first_q       <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
